// File: rtl/pmem_pkg.sv
// Shared types for the physical-memory port arbiter: FSM encoding,
// memory base address and the registered request bundle.
package pmem_pkg;

  localparam int PMEM_AW = 64;
  localparam int PMEM_DW = 64;

  // Base of physical memory; reset vector region for instruction fetch.
  localparam logic [PMEM_AW-1:0] PMEM_START = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_LS = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [PMEM_AW-1:0]   addr;
    logic                 we;
    logic [PMEM_DW-1:0]   wdata;
    logic [PMEM_DW/8-1:0] wmask;
  } pmem_req_t;

endpackage

// File: rtl/pmem_req_mux.sv
// Priority selector between fetch and load/store: LS wins unless it has
// already taken MAX_LS_RUN grants in a row while a fetch was waiting.
module pmem_req_mux
  import pmem_pkg::*;
#(
  parameter int MAX_LS_RUN = 4,
  parameter int RW         = $clog2(MAX_LS_RUN + 1)
) (
  input  logic          if_req,
  input  logic          ls_req,
  input  logic          if_flush,
  input  logic [RW-1:0] ls_run,
  output logic          gnt_if,
  output logic          gnt_ls
);

  logic cap_hit;

  always_comb begin
    cap_hit = if_req && (ls_run == RW'(MAX_LS_RUN));
    gnt_ls  = ls_req && !cap_hit;
    gnt_if  = !gnt_ls && if_req && !if_flush;
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Single-port physical memory arbiter: one transaction in flight, LS priority
// with an anti-starvation cap for fetch, and fetch-response drop on redirect.
module pmem_arbiter
  import pmem_pkg::*;
#(
  parameter int MAX_LS_RUN = 4,
  parameter int AW         = 64,
  parameter int DW         = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_inst,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [DW/8-1:0] ls_wmask,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int RW = $clog2(MAX_LS_RUN + 1);

  arb_state_t    state, state_nxt;
  logic [RW-1:0] ls_run;
  logic          drop;
  logic          sel_if, sel_ls;
  pmem_req_t     req;

  pmem_req_mux #(
    .MAX_LS_RUN(MAX_LS_RUN),
    .RW        (RW)
  ) u_req_mux (
    .if_req  (if_req),
    .ls_req  (ls_req),
    .if_flush(if_flush),
    .ls_run  (ls_run),
    .gnt_if  (sel_if),
    .gnt_ls  (sel_ls)
  );

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (!reset) begin
          if (sel_ls) begin
            ls_gnt    = 1'b1;
            state_nxt = ARB_BUSY_LS;
          end else if (sel_if) begin
            if_gnt    = 1'b1;
            state_nxt = ARB_BUSY_IF;
          end
        end
      end
      ARB_BUSY_IF, ARB_BUSY_LS: begin
        if (mem_ready) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // mem_valid depends only on registered state, never on mem_ready.
  assign mem_valid = (state != ARB_IDLE);
  assign mem_we    = req.we;
  assign mem_wdata = req.wdata;
  assign mem_wmask = req.wmask;
  // The full fetch address is kept so bit 2 can pick the instruction half.
  assign mem_addr  = (state == ARB_BUSY_IF) ? {req.addr[AW-1:3], 3'b000} : req.addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ARB_IDLE;
      ls_run    <= '0;
      drop      <= 1'b0;
      req       <= '0;
      if_rvalid <= 1'b0;
      if_inst   <= '0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          drop <= 1'b0;
          if (if_gnt || !if_req) begin
            ls_run <= '0;
          end else if (ls_gnt && ls_run != RW'(MAX_LS_RUN)) begin
            ls_run <= ls_run + 1'b1;
          end
          if (ls_gnt) begin
            req.addr  <= ls_addr;
            req.we    <= ls_we;
            req.wdata <= ls_wdata;
            req.wmask <= ls_we ? ls_wmask : '0;
          end else if (if_gnt) begin
            req.addr  <= if_addr;
            req.we    <= 1'b0;
            req.wdata <= '0;
            req.wmask <= '0;
          end
        end
        ARB_BUSY_IF: begin
          if (mem_ready) begin
            drop <= 1'b0;
            // A redirect in the completion cycle also kills the response.
            if (!(drop || if_flush)) begin
              if_rvalid <= 1'b1;
              if_inst   <= req.addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            end
          end else if (if_flush) begin
            drop <= 1'b1;
          end
        end
        ARB_BUSY_LS: begin
          if (mem_ready) begin
            ls_rvalid <= 1'b1;
            ls_rdata  <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus a randomized
// run against a cycle-level transaction model of the arbitration rules.
module tb_pmem_arbiter;
  import pmem_pkg::*;

  localparam int MAX = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [63:0] if_addr;
  logic [31:0] if_inst;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_valid, mem_we, mem_ready;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pmem_arbiter #(.MAX_LS_RUN(MAX), .AW(64), .DW(64)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_inst(if_inst),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0; if_flush = 0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; if_req = 1; ls_req = 1; mem_ready = 1; if_addr = 64'h8000_0004;
    tick(); tick(); sample();
    total++; if ({if_gnt, ls_gnt, mem_valid, mem_we, if_rvalid, ls_rvalid} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {if_gnt, ls_gnt, mem_valid, mem_we, if_rvalid, ls_rvalid}); end
    total++; if (mem_addr !== 64'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    total++; if (mem_wmask !== 8'h0 || mem_wdata !== 64'h0) begin
      bad++; $display("FAIL reset_wr: got mask %h data %h want 0", mem_wmask, mem_wdata); end
    total++; if (if_inst !== 32'h0 || ls_rdata !== 64'h0) begin
      bad++; $display("FAIL reset_rdata: got inst %h rdata %h want 0", if_inst, ls_rdata); end
    reset = 0; clear_inputs();
    tick();
  endtask

  task automatic test_lone_fetch();
    if_req = 1; if_addr = 64'h8000_0004;
    sample();
    total++; if ({if_gnt, ls_gnt} !== 2'b10) begin bad++; $display("FAIL fetch_gnt: got %b want 10", {if_gnt, ls_gnt}); end
    tick(); if_req = 0; mem_ready = 1; mem_rdata = 64'h1111_2222_3333_4444;
    sample();
    total++; if (mem_valid !== 1'b1 || mem_addr !== 64'h8000_0000) begin
      bad++; $display("FAIL fetch_mem: got valid %b addr %h want 1 80000000", mem_valid, mem_addr); end
    total++; if (mem_we !== 1'b0 || mem_wmask !== 8'h0) begin
      bad++; $display("FAIL fetch_rd: got we %b mask %h want 0 00", mem_we, mem_wmask); end
    tick(); mem_ready = 0; mem_rdata = {$urandom, $urandom};
    sample();
    total++; if (if_rvalid !== 1'b1 || if_inst !== 32'h1111_2222) begin
      bad++; $display("FAIL fetch_data: got rvalid %b inst %h want 1 11112222", if_rvalid, if_inst); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL fetch_done: got mem_valid %b want 0", mem_valid); end
    tick(); sample();
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_pulse: got rvalid %b want 0", if_rvalid); end
    tick();
  endtask

  task automatic test_contention();
    if_req = 1; if_addr = 64'h8000_0100;
    ls_req = 1; ls_we = 0; ls_addr = 64'h8000_2008; ls_wmask = 8'hFF;
    sample();
    total++; if ({if_gnt, ls_gnt} !== 2'b01) begin bad++; $display("FAIL cont_first: got if/ls %b want 01", {if_gnt, ls_gnt}); end
    tick(); ls_req = 0; mem_ready = 1; mem_rdata = 64'hA5A5_5A5A_0F0F_F0F0;
    sample();
    total++; if (mem_addr !== 64'h8000_2008 || mem_wmask !== 8'h0 || if_gnt !== 1'b0) begin
      bad++; $display("FAIL cont_load: got addr %h mask %h if_gnt %b want 80002008 00 0", mem_addr, mem_wmask, if_gnt); end
    tick(); mem_ready = 0;
    sample();
    total++; if (ls_rvalid !== 1'b1 || ls_rdata !== 64'hA5A5_5A5A_0F0F_F0F0) begin
      bad++; $display("FAIL cont_ldata: got rvalid %b data %h want 1 a5a55a5a0f0ff0f0", ls_rvalid, ls_rdata); end
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL cont_ifgnt: got %b want 1", if_gnt); end
    tick(); if_req = 0; mem_ready = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    sample();
    total++; if (mem_addr !== 64'h8000_0100) begin bad++; $display("FAIL cont_faddr: got %h want 80000100", mem_addr); end
    tick(); mem_ready = 0;
    sample();
    total++; if (if_rvalid !== 1'b1 || if_inst !== 32'h89AB_CDEF) begin
      bad++; $display("FAIL cont_inst: got rvalid %b inst %h want 1 89abcdef", if_rvalid, if_inst); end
    tick();
  endtask

  task automatic test_starvation();
    int seq[$];
    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    ls_req = 1; ls_we = 0; ls_addr = 64'h8000_4000; if_req = 1; if_addr = 64'h8000_0040;
    mem_ready = 1;
    for (int c = 0; c < 40 && seq.size() < 10; c++) begin
      sample();
      if (ls_gnt) seq.push_back(0);
      if (if_gnt) seq.push_back(1);
      tick();
    end
    total++; if (seq.size() != 10) begin bad++; $display("FAIL starve_count: got %0d grants want 10", seq.size()); end
    for (int i = 0; i < seq.size() && i < 10; i++) begin
      total++; if (seq[i] != exp_seq[i]) begin
        bad++; $display("FAIL starve_order[%0d]: got %s want %s", i, seq[i] ? "IF" : "LS", exp_seq[i] ? "IF" : "LS"); end
    end
    ls_req = 0; if_req = 0;
    tick(); tick(); mem_ready = 0;
  endtask

  task automatic test_flush();
    int rv = 0;
    if_req = 1; if_addr = 64'h8000_0010;
    sample();
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL flush_gnt: got %b want 1", if_gnt); end
    tick(); if_req = 0; if_flush = 1; mem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      sample();
      total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL flush_hold[%0d]: got mem_valid %b want 1", c, mem_valid); end
      if (if_rvalid) rv++;
      tick(); if_flush = 0;
    end
    mem_ready = 1; mem_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
    sample(); if (if_rvalid) rv++;
    tick(); mem_ready = 0; if_req = 1; if_addr = 64'h8000_0020;
    sample(); if (if_rvalid) rv++;
    total++; if (rv != 0) begin bad++; $display("FAIL flush_drop: got %0d rvalid pulses want 0", rv); end
    total++; if (if_gnt !== 1'b1 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL flush_next: got gnt %b valid %b want 1 0", if_gnt, mem_valid); end
    tick(); if_req = 0; mem_ready = 1; mem_rdata = 64'hCAFE_F00D_1234_5678;
    sample();
    tick(); mem_ready = 0;
    sample();
    total++; if (if_rvalid !== 1'b1 || if_inst !== 32'h1234_5678) begin
      bad++; $display("FAIL flush_after: got rvalid %b inst %h want 1 12345678", if_rvalid, if_inst); end
    tick(); if_req = 1; if_addr = 64'h8000_0024;
    sample();
    tick(); if_req = 0; if_flush = 1; mem_ready = 1;
    sample();
    tick(); if_flush = 0; mem_ready = 0;
    sample();
    total++; if (if_rvalid !== 1'b0 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL flush_same: got rvalid %b valid %b want 0 0", if_rvalid, mem_valid); end
    if_req = 1; if_flush = 1;
    tick(); sample();
    total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL flush_idle: got gnt %b want 0", if_gnt); end
    tick(); if_flush = 0;
    sample();
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL flush_regnt: got gnt %b want 1", if_gnt); end
    tick(); if_req = 0; mem_ready = 1; mem_rdata = 64'h7654_3210_FEDC_BA98;
    sample();
    tick(); mem_ready = 0;
    sample();
    total++; if (if_rvalid !== 1'b1 || if_inst !== 32'h7654_3210) begin
      bad++; $display("FAIL flush_hi: got rvalid %b inst %h want 1 76543210", if_rvalid, if_inst); end
    tick();
  endtask

  task automatic test_store();
    int pulses = 0;
    ls_req = 1; ls_we = 1; ls_addr = 64'h8000_1000; ls_wmask = 8'h0F; ls_wdata = 64'hDEAD_BEEF;
    sample();
    total++; if (ls_gnt !== 1'b1) begin bad++; $display("FAIL store_gnt: got %b want 1", ls_gnt); end
    tick(); ls_req = 0; ls_we = 0; ls_wmask = 8'hF0; ls_wdata = {$urandom, $urandom}; ls_addr = '0; mem_ready = 0;
    for (int c = 0; c < 5; c++) begin
      sample();
      total++; if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_wmask !== 8'h0F ||
                   mem_wdata !== 64'hDEAD_BEEF || mem_addr !== 64'h8000_1000) begin
        bad++; $display("FAIL store_hold[%0d]: got v%b we%b m%h d%h a%h want v1 we1 m0f ddeadbeef a80001000",
                        c, mem_valid, mem_we, mem_wmask, mem_wdata, mem_addr); end
      if (ls_rvalid) pulses++;
      tick();
    end
    mem_ready = 1;
    sample(); if (ls_rvalid) pulses++;
    tick(); mem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      sample(); if (ls_rvalid) pulses++;
      tick();
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL store_done: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_reset_mid();
    ls_req = 1; ls_we = 0; ls_addr = 64'h8000_3000;
    sample();
    total++; if (ls_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt: got %b want 1", ls_gnt); end
    tick(); ls_req = 0; mem_ready = 0;
    sample();
    tick(); reset = 1; mem_ready = 1;
    sample();
    tick(); reset = 0; mem_ready = 0; if_req = 1; if_addr = 64'h8000_0008;
    sample();
    total++; if (mem_valid !== 1'b0 || ls_rvalid !== 1'b0) begin
      bad++; $display("FAIL rmid_abort: got valid %b rvalid %b want 0 0", mem_valid, ls_rvalid); end
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rmid_ifgnt: got %b want 1", if_gnt); end
    tick(); if_req = 0; mem_ready = 1; mem_rdata = 64'h0BAD_F00D_600D_CAFE;
    sample();
    tick(); mem_ready = 0;
    sample();
    total++; if (if_rvalid !== 1'b1 || if_inst !== 32'h600D_CAFE) begin
      bad++; $display("FAIL rmid_fetch: got rvalid %b inst %h want 1 600dcafe", if_rvalid, if_inst); end
    tick();
  endtask

  // Cycle-level transaction model: at most one request in flight, LS priority
  // with a run cap while fetch waits, flush drops the in-flight fetch.
  task automatic test_random();
    bit busy = 0, kind_if = 0, mdrop = 0, e_we = 0, e_hi = 0;
    bit exp_ifv = 0, exp_lsv = 0, exp_load = 0, g_if = 0, g_ls = 0;
    int run = 0;
    logic [63:0] e_addr = '0, e_wdata = '0, exp_rdata = '0;
    logic [7:0]  e_wmask = '0;
    logic [31:0] exp_inst = '0;
    clear_inputs(); reset = 1;
    tick(); tick(); reset = 0;
    for (int c = 0; c < 800; c++) begin
      if (g_if) if_req = 0;
      if (g_ls) ls_req = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = PMEM_START + 64'($urandom_range(0, 1023)) * 4;
      end
      if (!ls_req && $urandom_range(0, 1) == 0) begin
        ls_req = 1; ls_we = 1'($urandom); ls_addr = PMEM_START + 64'($urandom_range(0, 8191));
        ls_wdata = {$urandom, $urandom}; ls_wmask = 8'($urandom);
      end
      if_flush  = ($urandom_range(0, 7) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = {$urandom, $urandom};
      sample();
      g_ls = !busy && ls_req && !(if_req && run == MAX);
      g_if = !busy && !g_ls && if_req && !if_flush;
      total++; if ({if_gnt, ls_gnt} !== {g_if, g_ls}) begin
        bad++; $display("FAIL rnd_gnt c%0d: got if/ls %b want %b", c, {if_gnt, ls_gnt}, {g_if, g_ls}); end
      total++; if (mem_valid !== busy) begin bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, mem_valid, busy); end
      if (busy) begin
        total++; if (mem_addr !== e_addr || mem_we !== e_we || mem_wmask !== e_wmask) begin
          bad++; $display("FAIL rnd_req c%0d: got a%h we%b m%h want a%h we%b m%h",
                          c, mem_addr, mem_we, mem_wmask, e_addr, e_we, e_wmask); end
        if (e_we) begin
          total++; if (mem_wdata !== e_wdata) begin bad++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mem_wdata, e_wdata); end
        end
      end
      total++; if (if_rvalid !== exp_ifv) begin bad++; $display("FAIL rnd_ifv c%0d: got %b want %b", c, if_rvalid, exp_ifv); end
      if (exp_ifv) begin
        total++; if (if_inst !== exp_inst) begin bad++; $display("FAIL rnd_inst c%0d: got %h want %h", c, if_inst, exp_inst); end
      end
      total++; if (ls_rvalid !== exp_lsv) begin bad++; $display("FAIL rnd_lsv c%0d: got %b want %b", c, ls_rvalid, exp_lsv); end
      if (exp_lsv && exp_load) begin
        total++; if (ls_rdata !== exp_rdata) begin bad++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, ls_rdata, exp_rdata); end
      end
      exp_ifv = 0; exp_lsv = 0;
      if (busy) begin
        if (mem_ready) begin
          if (kind_if) begin
            exp_ifv  = !(mdrop || if_flush);
            exp_inst = e_hi ? mem_rdata[63:32] : mem_rdata[31:0];
          end else begin
            exp_lsv = 1; exp_rdata = mem_rdata; exp_load = !e_we;
          end
          busy = 0; mdrop = 0;
        end else if (kind_if && if_flush) begin
          mdrop = 1;
        end
      end else if (g_ls) begin
        busy = 1; kind_if = 0; e_addr = ls_addr; e_we = ls_we; e_wdata = ls_wdata;
        e_wmask = ls_we ? ls_wmask : 8'h0;
        run = if_req ? ((run < MAX) ? run + 1 : MAX) : 0;
      end else if (g_if) begin
        busy = 1; kind_if = 1; e_addr = {if_addr[63:3], 3'b000}; e_we = 0; e_wmask = 8'h0;
        e_hi = if_addr[2]; run = 0;
      end else if (!if_req) begin
        run = 0;
      end
      tick();
    end
    clear_inputs();
    tick(); tick();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_lone_fetch();
    test_contention();
    test_starvation();
    test_flush();
    test_store();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
